// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port among D0, D1, I0, I1 (dcache over icache, round-robin within class).
// Latency: 1 cycle from a request seen in IDLE to RAM being driven; words then stream back-to-back until release.
// Backpressure: the owner's wait drops only on a completed word (ramstate ACCESS); all other waits stay high.
// Ports:
//   CLK, rst                    clock and asynchronous active-high reset
//   iREN, iaddr                 icache read request / word address, per core
//   dREN, dWEN, daddr, dstore   dcache read / write request, address, store data, per core
//   iwait, dwait                per-requester wait, low for the cycle the owner's word completes
//   iload, dload                ramload broadcast to every requester
//   ramREN, ramWEN, ramaddr, ramstore, ramload, ramstate   RAM port
module mem_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [1:0]        iREN,
  input  logic [1:0][31:0]  iaddr,
  input  logic [1:0]        dREN,
  input  logic [1:0]        dWEN,
  input  logic [1:0][31:0]  daddr,
  input  logic [1:0][31:0]  dstore,
  output logic [1:0]        iwait,
  output logic [1:0]        dwait,
  output logic [1:0][31:0]  iload,
  output logic [1:0][31:0]  dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [31:0]       ramaddr,
  output logic [31:0]       ramstore,
  input  logic [31:0]       ramload,
  input  logic [1:0]        ramstate
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  logic [0:0] state;
  logic [1:0] owner;
  logic [3:0] hold_cnt;
  logic       rr_d;
  logic       rr_i;

  // Requester IDs: 0 = D0, 1 = D1, 2 = I0, 3 = I1.
  logic [3:0] pend;
  assign pend = {iREN, dREN | dWEN};

  logic       own_req;
  logic       owning;
  logic       complete;
  logic       others;
  logic [4:0] hold_next;
  logic       limit_hit;
  logic       release_now;

  assign own_req   = pend[owner];
  assign owning    = (state == OWN) && own_req;
  assign complete  = owning && (ramstate == RAM_ACCESS);
  assign others    = |(pend & ~(4'b0001 << owner));
  assign hold_next = {1'b0, hold_cnt} + 5'd1;
  assign limit_hit = hold_next >= 5'(MAX_HOLD);

  // A dropped request releases immediately; otherwise yield only on a completed
  // word that reaches the hold limit while somebody else is waiting.
  assign release_now = (state == OWN) && (!own_req || (complete && limit_hit && others));

  // Winner selection: prefer the core the class pointer names, else its sibling.
  logic       d_sel;
  logic       i_sel;
  logic [1:0] winner;

  assign d_sel  = pend[{1'b0, rr_d}] ? rr_d : ~rr_d;
  assign i_sel  = pend[{1'b1, rr_i}] ? rr_i : ~rr_i;
  assign winner = (|pend[1:0]) ? {1'b0, d_sel} : {1'b1, i_sel};

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 2'b11;
    dwait    = 2'b11;
    if (owning) begin
      if (!owner[1]) begin
        // Write wins when a dcache raises both strobes.
        ramWEN   = dWEN[owner[0]];
        ramREN   = dREN[owner[0]] & ~dWEN[owner[0]];
        ramaddr  = daddr[owner[0]];
        ramstore = dstore[owner[0]];
      end else begin
        ramREN   = 1'b1;
        ramaddr  = iaddr[owner[0]];
      end
    end
    if (complete) begin
      if (owner[1]) iwait[owner[0]] = 1'b0;
      else          dwait[owner[0]] = 1'b0;
    end
  end

  assign iload = {ramload, ramload};
  assign dload = {ramload, ramload};

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 2'd0;
      hold_cnt <= 4'd0;
      rr_d     <= 1'b0;
      rr_i     <= 1'b0;
    end else if (state == IDLE) begin
      if (|pend) begin
        owner    <= winner;
        hold_cnt <= 4'd0;
        state    <= OWN;
      end
    end else begin
      if (complete && (hold_cnt != 4'hF)) hold_cnt <= hold_cnt + 4'd1;
      if (release_now) begin
        state <= IDLE;
        // Point the class at the sibling of the core that just finished.
        if (owner[1]) rr_i <= ~owner[0];
        else          rr_d <= ~owner[0];
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MAXH = 4;

  logic              CLK = 1'b0;
  logic              rst;
  logic [1:0]        iREN;
  logic [1:0][31:0]  iaddr;
  logic [1:0]        dREN;
  logic [1:0]        dWEN;
  logic [1:0][31:0]  daddr;
  logic [1:0][31:0]  dstore;
  logic [1:0]        iwait;
  logic [1:0]        dwait;
  logic [1:0][31:0]  iload;
  logic [1:0][31:0]  dload;
  logic              ramREN;
  logic              ramWEN;
  logic [31:0]       ramaddr;
  logic [31:0]       ramstore;
  logic [31:0]       ramload;
  logic [1:0]        ramstate;

  mem_arbiter #(.MAX_HOLD(MAXH)) dut (
    .CLK(CLK), .rst(rst),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: who holds the RAM (-1 = nobody), words completed in this
  // grant, and the per-class "next core to favour" pointer (0 = D, 1 = I).
  int m_own;
  int m_cnt;
  int m_rr [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pend(input int id);
    if (id < 2) return bit'(dREN[id] | dWEN[id]);
    return bit'(iREN[id-2]);
  endfunction

  // Settle the current inputs and compare every output against the model.
  task automatic look();
    bit          drv;
    bit          done;
    logic [1:0]  ew_i;
    logic [1:0]  ew_d;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    #2;
    drv  = (m_own >= 0) && m_pend(m_own);
    done = drv && (ramstate == 2'd2);
    ew_i = 2'b11;
    ew_d = 2'b11;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    if (done) begin
      if (m_own < 2) ew_d[m_own] = 1'b0;
      else           ew_i[m_own-2] = 1'b0;
    end
    if (drv) begin
      if (m_own < 2) begin
        e_wen   = dWEN[m_own];
        e_ren   = dREN[m_own] & ~dWEN[m_own];
        e_addr  = daddr[m_own];
        e_store = dstore[m_own];
      end else begin
        e_ren  = 1'b1;
        e_addr = iaddr[m_own-2];
      end
    end
    chk("ramREN", 32'(ramREN), 32'(e_ren));
    chk("ramWEN", 32'(ramWEN), 32'(e_wen));
    chk("iwait", 32'(iwait), 32'(ew_i));
    chk("dwait", 32'(dwait), 32'(ew_d));
    chk("iload1", iload[1], ramload);
    chk("dload0", dload[0], ramload);
    if (drv) chk("ramaddr", ramaddr, e_addr);
    if (e_wen) chk("ramstore", ramstore, e_store);
  endtask

  // Clock edge: advance the model from the inputs that were presented.
  task automatic tick();
    int  w;
    bit  rel;
    bit  oth;
    @(posedge CLK);
    if (m_own < 0) begin
      w = -1;
      if (m_pend(0) || m_pend(1))
        w = m_pend(m_rr[0]) ? m_rr[0] : 1 - m_rr[0];
      else if (m_pend(2) || m_pend(3))
        w = 2 + (m_pend(2 + m_rr[1]) ? m_rr[1] : 1 - m_rr[1]);
      m_own = w;
      m_cnt = 0;
    end else begin
      rel = 1'b0;
      if (!m_pend(m_own)) rel = 1'b1;
      else if (ramstate == 2'd2) begin
        m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
        oth = 1'b0;
        for (int j = 0; j < 4; j++) if (j != m_own && m_pend(j)) oth = 1'b1;
        if (m_cnt >= MAXH && oth) rel = 1'b1;
      end
      if (rel) begin
        m_rr[m_own / 2] = 1 - (m_own % 2);
        m_own = -1;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = 2'd0;
    m_own = -1; m_cnt = 0; m_rr = '{0, 0};

    // Reset values
    #2;
    chk("rst ramREN", 32'(ramREN), 32'd0);
    chk("rst ramWEN", 32'(ramWEN), 32'd0);
    chk("rst ramaddr", ramaddr, 32'd0);
    chk("rst ramstore", ramstore, 32'd0);
    chk("rst iwait", 32'(iwait), 32'd3);
    chk("rst dwait", 32'(dwait), 32'd3);
    #6 rst = 1'b0;
    tick();

    // Reset while D0 owns: strobe drops immediately, state back to reset values
    dREN = 2'b01; daddr[0] = 32'h40; ramstate = 2'd1;
    look(); tick();
    look();
    chk("A ramREN owned", 32'(ramREN), 32'd1);
    rst = 1'b1;
    #1;
    chk("A ramREN in reset", 32'(ramREN), 32'd0);
    chk("A dwait in reset", 32'(dwait), 32'd3);
    m_own = -1; m_cnt = 0; m_rr = '{0, 0};
    dREN = 2'b00;
    @(negedge CLK);
    rst = 1'b0;
    tick();
    look();
    chk("A rr_d", 32'(dut.rr_d), 32'd0);
    chk("A rr_i", 32'(dut.rr_i), 32'd0);
    tick();

    // D0 and I1 together: D0 first for two words, then I1
    dREN = 2'b01; daddr[0] = 32'h100; iREN = 2'b10; iaddr[1] = 32'h2000; ramstate = 2'd2;
    look(); tick();
    look();
    chk("B d0 word0 dwait", 32'(dwait), 32'd2);
    chk("B d0 word0 addr", ramaddr, 32'h100);
    chk("B i1 waits", 32'(iwait), 32'd3);
    tick();
    daddr[0] = 32'h104;
    look();
    chk("B d0 word1 dwait", 32'(dwait), 32'd2);
    chk("B d0 word1 addr", ramaddr, 32'h104);
    tick();
    dREN = 2'b00;
    look();
    chk("B release no strobe", 32'(ramREN), 32'd0);
    tick();
    look(); tick();
    look();
    chk("B i1 iwait", 32'(iwait), 32'd1);
    chk("B i1 addr", ramaddr, 32'h2000);
    tick();
    iREN = 2'b00;
    look(); tick();

    // D1 write with both strobes high
    dREN = 2'b10; dWEN = 2'b10; daddr[1] = 32'h3100; dstore[1] = 32'hDEADBEEF;
    look(); tick();
    look();
    chk("C ramWEN", 32'(ramWEN), 32'd1);
    chk("C ramREN", 32'(ramREN), 32'd0);
    chk("C ramaddr", ramaddr, 32'h3100);
    chk("C ramstore", ramstore, 32'hDEADBEEF);
    chk("C dwait", 32'(dwait), 32'd1);
    tick();
    dREN = 2'b00; dWEN = 2'b00;
    look(); tick();

    // D0/D1 contend with I0 pending: D grants alternate, MAX_HOLD words each
    dREN = 2'b11; daddr[0] = 32'h200; daddr[1] = 32'h300;
    iREN = 2'b01; iaddr[0] = 32'h500;
    look(); tick();
    for (int g = 0; g < 3; g++) begin
      for (int w = 0; w < MAXH; w++) begin
        look();
        chk("D rotation dwait", 32'(dwait), (g % 2 == 1) ? 32'd1 : 32'd2);
        chk("D icache starved", 32'(iwait), 32'd3);
        tick();
      end
      look();
      chk("D gap ramREN", 32'(ramREN), 32'd0);
      tick();
    end
    dREN = 2'b00;
    look(); tick();
    look(); tick();

    // I0 retries through BUSY/ERROR/BUSY, completes on ACCESS
    ramload = 32'h12345678;
    for (int s = 0; s < 3; s++) begin
      ramstate = (s == 1) ? 2'd3 : 2'd1;
      look();
      chk("E iwait retry", 32'(iwait), 32'd3);
      tick();
    end
    ramstate = 2'd2;
    look();
    chk("E iwait access", 32'(iwait), 32'd2);
    chk("E iload0", iload[0], 32'h12345678);
    tick();
    chk("E hold_cnt", 32'(dut.hold_cnt), 32'd1);

    // Owner drops its request on an ACCESS cycle
    iREN = 2'b00;
    look();
    chk("F no wait pulse", 32'(iwait), 32'd3);
    chk("F no strobe", 32'(ramREN), 32'd0);
    tick();
    chk("F hold_cnt kept", 32'(dut.hold_cnt), 32'd1);
    chk("F rr_i flipped", 32'(dut.rr_i), 32'd1);

    // Randomised traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 3) == 0) dREN[k] = ~dREN[k];
        if ($urandom_range(0, 5) == 0) dWEN[k] = ~dWEN[k];
        if ($urandom_range(0, 3) == 0) iREN[k] = ~iREN[k];
        daddr[k]  = $urandom;
        dstore[k] = $urandom;
        iaddr[k]  = $urandom;
      end
      ramstate = 2'($urandom_range(0, 3));
      ramload  = $urandom;
      look();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
